// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_pkg
//  Description : Shared types and helpers for the I2S/TDM bus master:
//                FSM state and word-select mode enums, frame geometry and
//                index helpers, parameter range check.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Two slots drive a 50% I2S word select; more slots drive a one-bit frame pulse.
  typedef enum logic [0:0] {
    WS_I2S       = 1'b0,
    WS_TDM_PULSE = 1'b1
  } ws_mode_e;

  function automatic int frame_bits(input int num_channels, input int slot_width);
    return num_channels * slot_width;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic ws_mode_e ws_mode(input int num_channels);
    return (num_channels == 2) ? WS_I2S : WS_TDM_PULSE;
  endfunction

  // Word select leads the data by one bit, so it is evaluated for the following bit.
  function automatic logic ws_level(input ws_mode_e mode, input int bit_idx,
                                    input int fbits, input int slot_width);
    int nxt;
    nxt = (bit_idx + 1) % fbits;
    if (mode == WS_I2S) begin
      return (nxt >= slot_width) && (nxt < 2 * slot_width);
    end
    return bit_idx == fbits - 1;
  endfunction

  // Slot positions past the sample width carry padding zeros.
  function automatic logic in_sample(input int pos, input int sample_width);
    return pos < sample_width;
  endfunction

  // Bit of the packed frame carried at (slot, pos), MSB of each sample first.
  function automatic int data_index(input int slot, input int pos, input int sample_width);
    return slot * sample_width + sample_width - 1 - pos;
  endfunction

  function automatic bit params_ok(input int sck_div, input int sample_width,
                                   input int slot_width, input int num_channels);
    return (sck_div >= 2) && (sample_width >= 1) && (sample_width <= slot_width) &&
           (num_channels >= 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_clk_gen
//  Description : Bit-clock divider. Toggles sck every SCK_DIV clocks while
//                running and flags the cycle of each rising / falling toggle.
//                Parks with sck low and the divider cleared when stopped.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_clk_gen #(
  parameter int SCK_DIV = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic sck_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);
  import i2s_pkg::*;

  localparam int CNT_W = idx_width(SCK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             half_done;

  assign half_done   = run_i && (cnt_q == CNT_LAST);
  assign rise_tick_o = half_done && !sck_q;
  assign fall_tick_o = half_done && sck_q;
  assign sck_o       = sck_q;

  // Count each half period and flip sck at its end; hold everything low when stopped.
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!run_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (half_done) begin
      cnt_d = '0;
      sck_d = !sck_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Divider state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2s_tdm_controller.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_tdm_controller
//  Description : I2S / TDM bus master. Generates sck and ws, serialises
//                parallel multi-channel frames onto sd_out and assembles
//                sd_in into parallel frames. One-deep tx holding register
//                with valid/ready; whole frames only.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_tdm_controller #(
  parameter int SCK_DIV      = 32,
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int NUM_CHANNELS = 2
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 enable_in,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] tx_data_in,
  input  logic                                 tx_valid_in,
  output logic                                 tx_ready_out,
  output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] rx_data_out,
  output logic                                 rx_valid_out,
  output logic                                 underrun_out,
  output logic                                 sck,
  output logic                                 ws,
  output logic                                 sd_out,
  input  logic                                 sd_in
);
  import i2s_pkg::*;

  localparam int       FRAME_BITS = frame_bits(NUM_CHANNELS, SLOT_WIDTH);
  localparam int       DATA_W     = NUM_CHANNELS * SAMPLE_WIDTH;
  localparam int       BIT_W      = idx_width(FRAME_BITS);
  localparam int       SLOT_W     = idx_width(NUM_CHANNELS);
  localparam int       POS_W      = idx_width(SLOT_WIDTH);
  localparam int       DIDX_W     = idx_width(DATA_W);
  localparam ws_mode_e WS_MODE    = ws_mode(NUM_CHANNELS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(SLOT_WIDTH - 1);

  if (!params_ok(SCK_DIV, SAMPLE_WIDTH, SLOT_WIDTH, NUM_CHANNELS)) begin : g_param_check
    $error("i2s_tdm_controller: parameter out of range");
  end

  state_e              state_q, state_d;
  logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [DATA_W-1:0]   frame_q, frame_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [DATA_W-1:0]   rx_asm_q, rx_asm_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                underrun_q, underrun_d;
  logic                ws_q, ws_d;
  logic                sd_q, sd_d;

  logic                run;
  logic                rise_tick;
  logic                fall_tick;
  logic                accept;
  logic                load;
  logic                bit_step;
  logic [DIDX_W-1:0]   rx_idx;
  logic [DIDX_W-1:0]   tx_idx;

  assign run    = (state_q == ST_RUN);
  assign accept = tx_valid_in && !hold_full_q;
  assign rx_idx = DIDX_W'(data_index(int'(slot_q), int'(pos_q), SAMPLE_WIDTH));

  i2s_clk_gen #(
    .SCK_DIV (SCK_DIV)
  ) u_clk_gen (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .run_i       (run),
    .sck_o       (sck),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  // Frame sequencing, tx holding register, rx assembly and next pin levels.
  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    slot_d      = slot_q;
    pos_d       = pos_q;
    frame_d     = frame_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_asm_d    = rx_asm_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    ws_d        = ws_q;
    sd_d        = sd_q;
    load        = 1'b0;
    bit_step    = 1'b0;
    tx_idx      = '0;

    case (state_q)
      ST_IDLE: begin
        ws_d = 1'b0;
        sd_d = 1'b0;
        if (enable_in) begin
          state_d   = ST_RUN;
          bit_idx_d = '0;
          slot_d    = '0;
          pos_d     = '0;
          load      = 1'b1;
          bit_step  = 1'b1;
        end
      end
      ST_RUN: begin
        // Codec data is captured on the rising bit-clock edge.
        if (rise_tick) begin
          if (in_sample(int'(pos_q), SAMPLE_WIDTH)) begin
            rx_asm_d[rx_idx] = sd_in;
          end
          if (bit_idx_q == BIT_LAST) begin
            rx_data_d  = rx_asm_d;
            rx_valid_d = 1'b1;
          end
        end
        // The falling edge moves to the next bit; a frame boundary decides run/stop.
        if (fall_tick) begin
          bit_step = 1'b1;
          if (bit_idx_q == BIT_LAST) begin
            bit_idx_d = '0;
            slot_d    = '0;
            pos_d     = '0;
            if (enable_in) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            if (pos_q == POS_LAST) begin
              pos_d  = '0;
              slot_d = slot_q + 1'b1;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Start of frame: take the held frame, or send silence and flag the underrun.
    if (load) begin
      if (hold_full_q) begin
        frame_d = hold_q;
      end else begin
        frame_d    = '0;
        underrun_d = 1'b1;
      end
      hold_full_d = 1'b0;
    end

    // An accept on the load cycle is kept for the following frame.
    if (accept) begin
      hold_d      = tx_data_in;
      hold_full_d = 1'b1;
    end

    if (bit_step) begin
      if (state_d == ST_RUN) begin
        ws_d = ws_level(WS_MODE, int'(bit_idx_d), FRAME_BITS, SLOT_WIDTH);
        if (in_sample(int'(pos_d), SAMPLE_WIDTH)) begin
          tx_idx = DIDX_W'(data_index(int'(slot_d), int'(pos_d), SAMPLE_WIDTH));
          sd_d   = frame_d[tx_idx];
        end else begin
          sd_d = 1'b0;
        end
      end else begin
        ws_d = 1'b0;
        sd_d = 1'b0;
      end
    end
  end

  // Controller state registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      bit_idx_q   <= '0;
      slot_q      <= '0;
      pos_q       <= '0;
      frame_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_asm_q    <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      ws_q        <= 1'b0;
      sd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      slot_q      <= slot_d;
      pos_q       <= pos_d;
      frame_q     <= frame_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_asm_q    <= rx_asm_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      ws_q        <= ws_d;
      sd_q        <= sd_d;
    end
  end

  assign tx_ready_out = !hold_full_q;
  assign rx_data_out  = rx_data_q;
  assign rx_valid_out = rx_valid_q;
  assign underrun_out = underrun_q;
  assign ws           = ws_q;
  assign sd_out       = sd_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tdm_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_tdm_controller
//  Description : Bench for two controller configurations (I2S stereo and
//                4-slot TDM) against a timeline model of the bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tdm_controller;

  localparam int NK = 2;
  localparam int C_DIV [NK] = '{2, 3};
  localparam int C_SW  [NK] = '{4, 8};
  localparam int C_SL  [NK] = '{6, 8};
  localparam int C_NC  [NK] = '{2, 4};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  en  = '0;
  logic [1:0]  txv = '0;
  logic [1:0]  sdi = '0;
  logic [7:0]  txd0 = '0;
  logic [31:0] txd1 = '0;
  wire  [1:0]  rdy, rxv, und, sck_w, ws_w, sdo;
  wire  [7:0]  rxd0;
  wire  [31:0] rxd1;
  bit          loop_mode = 1'b0;
  bit          chk_on = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  // Model state: time since frame start in clk cycles, holding register, frames.
  int       m_t      [NK];
  bit       m_run    [NK];
  bit       m_hfull  [NK];
  bit [31:0] m_hold  [NK];
  bit [31:0] m_frame [NK];
  bit [31:0] m_asm   [NK];
  bit [31:0] m_rxd   [NK];
  bit       m_rxv    [NK];
  bit       m_und    [NK];

  always #5 clk = ~clk;

  i2s_tdm_controller #(.SCK_DIV(2), .SAMPLE_WIDTH(4), .SLOT_WIDTH(6), .NUM_CHANNELS(2)) u_dut_i2s (
    .clk_in(clk), .rst_in(rst), .enable_in(en[0]), .tx_data_in(txd0), .tx_valid_in(txv[0]),
    .tx_ready_out(rdy[0]), .rx_data_out(rxd0), .rx_valid_out(rxv[0]), .underrun_out(und[0]),
    .sck(sck_w[0]), .ws(ws_w[0]), .sd_out(sdo[0]), .sd_in(sdi[0]));

  i2s_tdm_controller #(.SCK_DIV(3), .SAMPLE_WIDTH(8), .SLOT_WIDTH(8), .NUM_CHANNELS(4)) u_dut_tdm (
    .clk_in(clk), .rst_in(rst), .enable_in(en[1]), .tx_data_in(txd1), .tx_valid_in(txv[1]),
    .tx_ready_out(rdy[1]), .rx_data_out(rxd1), .rx_valid_out(rxv[1]), .underrun_out(und[1]),
    .sck(sck_w[1]), .ws(ws_w[1]), .sd_out(sdo[1]), .sd_in(sdi[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_t[k] = 0; m_run[k] = 0; m_hfull[k] = 0; m_hold[k] = 0; m_frame[k] = 0;
    m_asm[k] = 0; m_rxd[k] = 0; m_rxv[k] = 0; m_und[k] = 0;
  endtask

  // One clk edge of the bus timeline: bit b spans cycles [2*D*b, 2*D*(b+1)),
  // sck rises D cycles into each bit, frames are FRAME_BITS bits long.
  task automatic model_step(input int k, input bit en_v, input bit txv_v,
                            input bit [31:0] txd_v, input bit sdi_v);
    int d, sw, sl, fb, b, s, p;
    bit acc, do_load;
    d = C_DIV[k]; sw = C_SW[k]; sl = C_SL[k]; fb = C_NC[k] * sl;
    acc = txv_v && !m_hfull[k];
    do_load = 0;
    m_rxv[k] = 0;
    m_und[k] = 0;
    if (!m_run[k]) begin
      if (en_v) begin
        m_run[k] = 1; m_t[k] = 0; do_load = 1;
      end
    end else begin
      m_t[k]++;
      if (m_t[k] % (2 * d) == d) begin
        b = m_t[k] / (2 * d); s = b / sl; p = b % sl;
        if (p < sw) m_asm[k][s * sw + sw - 1 - p] = sdi_v;
        if (b == fb - 1) begin
          m_rxd[k] = m_asm[k]; m_rxv[k] = 1;
        end
      end
      if (m_t[k] == 2 * d * fb) begin
        m_t[k] = 0;
        if (en_v) do_load = 1; else m_run[k] = 0;
      end
    end
    if (do_load) begin
      if (m_hfull[k]) begin
        m_frame[k] = m_hold[k]; m_hfull[k] = 0;
      end else begin
        m_frame[k] = 0; m_und[k] = 1;
      end
    end
    if (acc) begin
      m_hold[k] = txd_v; m_hfull[k] = 1;
    end
  endtask

  // Expected {sck, ws, sd_out} for the current model time.
  function automatic logic [2:0] exp_pins(input int k);
    int d, sw, sl, fb, t, b, s, p, n;
    logic sc, w, sd;
    if (!m_run[k]) return 3'b000;
    d = C_DIV[k]; sw = C_SW[k]; sl = C_SL[k]; fb = C_NC[k] * sl; t = m_t[k];
    b = t / (2 * d); s = b / sl; p = b % sl;
    sc = ((t / d) % 2) == 1;
    n = (b + 1) % fb;
    if (C_NC[k] == 2) w = (n >= sl) && (n < 2 * sl);
    else              w = (b == fb - 1);
    sd = (p < sw) ? m_frame[k][s * sw + sw - 1 - p] : 1'b0;
    return {sc, w, sd};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, en[0], txv[0], {24'b0, txd0}, sdi[0]);
      model_step(1, en[1], txv[1], txd1, sdi[1]);
    end
  end

  // Serial input: loop back sd_out or random bits.
  always @(negedge clk) begin
    for (int k = 0; k < NK; k++) sdi[k] = loop_mode ? sdo[k] : 1'($urandom);
  end

  // Every cycle: all DUT outputs against the model.
  always @(negedge clk) begin : p_check
    logic [2:0] pins;
    if (chk_on) begin
      for (int k = 0; k < NK; k++) begin
        pins = exp_pins(k);
        chk($sformatf("k%0d_sck", k), 32'(sck_w[k]), 32'(pins[2]));
        chk($sformatf("k%0d_ws", k), 32'(ws_w[k]), 32'(pins[1]));
        chk($sformatf("k%0d_sd_out", k), 32'(sdo[k]), 32'(pins[0]));
        chk($sformatf("k%0d_tx_ready", k), 32'(rdy[k]), 32'(!m_hfull[k]));
        chk($sformatf("k%0d_rx_valid", k), 32'(rxv[k]), 32'(m_rxv[k]));
        chk($sformatf("k%0d_underrun", k), 32'(und[k]), 32'(m_und[k]));
        chk($sformatf("k%0d_rx_data", k), (k == 0) ? {24'b0, rxd0} : rxd1, m_rxd[k]);
      end
    end
  end

  task automatic wait_flag(input int k, input bit want_rx, input int budget, input string tag);
    int n;
    n = 0;
    while (((want_rx ? rxv[k] : und[k]) !== 1'b1) && n < budget) begin
      @(negedge clk); n++;
    end
    if (n >= budget) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_model_t(input int k, input int target, input int budget);
    int n;
    n = 0;
    while (!(m_run[k] && m_t[k] == target) && n < budget) begin
      @(negedge clk); n++;
    end
    if (n >= budget) chk($sformatf("k%0d_wait_t%0d_timeout", k, target), 32'd0, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_tx_ready", 32'(rdy), 32'h3);
    chk("rst_pins", {26'b0, sck_w, ws_w, sdo}, 32'h0);
    #2 rst = 1'b0;

    // Directed frames with loopback: L=0xA R=0x5, and 0x11..0x44 on TDM.
    @(negedge clk);
    loop_mode = 1'b1;
    txv = 2'b11; txd0 = 8'h5A; txd1 = 32'h4433_2211;
    @(negedge clk);
    txv = 2'b00; en = 2'b11;
    chk("ready_low_after_push", 32'(rdy), 32'h0);
    wait_flag(0, 1'b1, 200, "rx0");
    chk("loop_rx0", {24'b0, rxd0}, 32'h5A);
    @(negedge clk);
    chk("rx0_single_pulse", 32'(rxv[0]), 32'd0);
    wait_flag(0, 1'b0, 40, "und0");
    wait_flag(1, 1'b1, 400, "rx1");
    chk("loop_rx1", rxd1, 32'h4433_2211);

    // Disable at bit 3 of a frame: the frame runs out, then the bus parks.
    loop_mode = 1'b0;
    @(negedge clk);
    txv[0] = 1'b1; txd0 = 8'($urandom);
    @(negedge clk);
    txv[0] = 1'b0;
    wait_model_t(0, 12, 200);
    en[0] = 1'b0;
    repeat (60) @(negedge clk);
    chk("parked_pins0", {29'b0, sck_w[0], ws_w[0], sdo[0]}, 32'h0);
    txv[0] = 1'b1; txd0 = 8'($urandom);
    @(negedge clk);
    txv[0] = 1'b0; en[0] = 1'b1;

    // Reset in the middle of bit 7 with a frame waiting in the holding register.
    wait_model_t(0, 2, 200);
    txv[0] = 1'b1; txd0 = 8'($urandom);
    @(negedge clk);
    txv[0] = 1'b0;
    wait_model_t(0, 30, 200);
    chk("ready_low_before_rst", 32'(rdy[0]), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_pins", {26'b0, sck_w, ws_w, sdo}, 32'h0);
    chk("rst_mid_ready", 32'(rdy), 32'h3);
    chk("rst_mid_rx", {22'b0, rxv, und, rxd0}, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // Random traffic: random data, sparse valid, occasional enable drops.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
        txv[k] = ($urandom % 4) == 0;
        if (en[k]) begin
          if ($urandom % 300 == 0) en[k] = 1'b0;
        end else if ($urandom % 20 == 0) begin
          en[k] = 1'b1;
        end
      end
      txd0 = 8'($urandom);
      txd1 = $urandom;
    end
    txv = 2'b00;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_tdm_controller.md
Name: i2s_tdm_controller

Overview:
Parametrised I2S/TDM bus master. Generates sck and ws from the system clock, serialises parallel multi-channel frames onto sd_out, and deserialises sd_in into parallel frames. Sits between the audio sample pipeline (DSP/effects chain) and the codec pins. Generalises the fixed stereo clock generator to configurable channel count, slot/sample width and sck divider, and adds data paths with a valid/ready handshake.

Parameters:
SCK_DIV, 32, sck half-period in clk_in cycles (>=2); f_sck = f_clk/(2*SCK_DIV)
SAMPLE_WIDTH, 24, data bits per channel (<= SLOT_WIDTH)
SLOT_WIDTH, 32, sck periods per channel slot
NUM_CHANNELS, 2, slots per frame (>=2); 2 = I2S stereo ws, >2 = TDM pulse ws

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-high
enable_in  input  1  run request
tx_data_in  input  NUM_CHANNELS*SAMPLE_WIDTH  frame to send; channel c at [c*SAMPLE_WIDTH +: SAMPLE_WIDTH], channel 0 = slot 0 (left)
tx_valid_in  input  1  tx_data_in valid
tx_ready_out  output  1  holding register empty
rx_data_out  output  NUM_CHANNELS*SAMPLE_WIDTH  last received frame, same packing
rx_valid_out  output  1  one-cycle pulse, new rx frame
underrun_out  output  1  one-cycle pulse, frame started with no tx data
sck  output  1  bit clock
ws  output  1  word select / frame sync
sd_out  output  1  serial data to codec
sd_in  input  1  serial data from codec

Behaviour:
- Reset (async, immediate, also mid-frame): sck=0, ws=0, sd_out=0, rx_valid_out=0, underrun_out=0, rx_data_out=0, holding register empty (tx_ready_out=1), state IDLE, counters 0. Handshakes ignored while rst_in=1.
- FRAME_BITS = NUM_CHANNELS*SLOT_WIDTH; bit_idx 0..FRAME_BITS-1; slot s = bit_idx/SLOT_WIDTH, position p = bit_idx%SLOT_WIDTH.
- States IDLE, RUN. IDLE: sck/ws/sd_out held 0, divider held 0. IDLE->RUN on cycle with enable_in=1: bit_idx=0, frame load (below), ws/sd_out for bit 0 registered the same edge; sck stays low.
- RUN: div_cnt counts 0..SCK_DIV-1; at SCK_DIV-1 sck toggles. Rising toggle: sample sd_in. Falling toggle: bit_idx advances (wraps FRAME_BITS-1 -> 0), ws/sd_out updated on the same edge.
- Wrap at falling edge: enable_in=0 -> IDLE (finishes whole frame; no partial frames). Else frame load.
- Frame load: holding full -> shift register <= holding, holding cleared. Holding empty -> shift register <= 0, underrun_out pulses 1 cycle. A tx accept in the same cycle lands in holding for the next frame (no bypass).
- Handshake: tx_ready_out = holding empty; accept when tx_valid_in & tx_ready_out; tx_data_in is don't-care otherwise.
- sd_out: p<SAMPLE_WIDTH -> sample bit SAMPLE_WIDTH-1-p of slot s (MSB first), else 0.
- ws leads data by one bit: NUM_CHANNELS=2: ws=1 iff ((bit_idx+1) mod FRAME_BITS) in [SLOT_WIDTH, 2*SLOT_WIDTH). NUM_CHANNELS>2: ws=1 iff bit_idx==FRAME_BITS-1.
- Rx: bit sampled at rising edge of bit_idx stored to slot s bit SAMPLE_WIDTH-1-p if p<SAMPLE_WIDTH. After the rising edge of bit FRAME_BITS-1, rx_data_out updates and rx_valid_out pulses the next cycle. No backpressure; unread frames overwritten. Frames aborted by reset are never emitted.
- Disable mid-frame: current frame, including its rx_valid_out, completes normally.

Decomposition:
- i2s_pkg: frame_bits(), slot/position helpers, ws mode enum (WS_I2S, WS_TDM_PULSE) derived from NUM_CHANNELS, parameter range checks.
- Sub-module i2s_clk_gen: divider producing sck, rise_tick, fall_tick; run input; resets/holds low in IDLE.

Test Plan:
- Params SCK_DIV=2, SAMPLE_WIDTH=4, SLOT_WIDTH=6, NUM_CHANNELS=2; reset, enable -> sck period 4 clk, first rising edge 2 clk after RUN entry, ws low 5 bits / high 6 / low 1, repeating every 12 bits.
- Same params, push tx L=0xA, R=0x5 -> sd_out frame 1010_00_0101_00; tx_ready_out low until next frame load, then high.
- Loop sd_out->sd_in -> rx_data_out = {4'h5,4'hA}, rx_valid_out single pulse after bit 11 rising edge; no push for next frame -> underrun_out pulse, sd_out all 0.
- NUM_CHANNELS=4, SAMPLE_WIDTH=SLOT_WIDTH=8, data 0x11,0x22,0x33,0x44 -> ws high only at bit 31, slots output in order, loopback matches.
- enable_in dropped at bit 3 -> frame completes to bit 11, then sck/ws/sd_out 0; re-enable restarts at bit 0.
- rst_in pulsed mid-frame at bit 7 -> all outputs 0 immediately, no rx_valid_out, tx_ready_out=1.
